// File: rtl/cv32e40p_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_fetch_aligner
// Description : Turns the 32-bit word stream from the prefetch buffer into a
//               stream of aligned instructions with their PCs. A 16-bit
//               residue register carries the upper half of a word across
//               cycles so compressed and word-straddling instructions can be
//               presented whole.
//               Build macro FETCH_ALIGNER_RVC_EN enables compressed support;
//               without it every word is a 32-bit instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_fetch_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    input  logic        if_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_aligned_o,
    output logic        instr_compressed_o,
    output logic [31:0] pc_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

    logic [31:0] pc;
    logic [31:0] pc_next;

    assign pc_o = pc;

`ifdef FETCH_ALIGNER_RVC_EN
    typedef enum logic [1:0] {
        ALIGNED    = 2'd0,
        MISALIGNED = 2'd1,
        BRANCH_MIS = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] residue;
    logic [15:0] residue_next;
    logic        unused_addr_bit;

    // Targets are halfword aligned, so bit 0 of the target carries no meaning.
    assign unused_addr_bit = branch_addr_i[0];

    // Output selection and next-state computation for the halfword aligner.
    always_comb begin
        instr_valid_o      = 1'b0;
        fetch_ready_o      = 1'b0;
        instr_aligned_o    = 32'h0;
        instr_compressed_o = 1'b0;
        pc_next            = pc;
        state_next         = state;
        residue_next       = residue;
        if (!rst_n) begin
            // Outputs stay quiet while in reset; registers load in always_ff.
            pc_next = pc;
        end else if (branch_i) begin
            pc_next      = {branch_addr_i[31:1], 1'b0};
            state_next   = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
            residue_next = 16'h0;
        end else begin
            case (state)
                ALIGNED: begin
                    instr_valid_o = fetch_valid_i;
                    if (fetch_rdata_i[1:0] == 2'b11) begin
                        instr_aligned_o = fetch_rdata_i;
                        if (fetch_valid_i && if_ready_i) begin
                            fetch_ready_o = 1'b1;
                            pc_next       = pc + 32'd4;
                        end
                    end else begin
                        instr_aligned_o    = {16'h0, fetch_rdata_i[15:0]};
                        instr_compressed_o = 1'b1;
                        if (fetch_valid_i && if_ready_i) begin
                            fetch_ready_o = 1'b1;
                            residue_next  = fetch_rdata_i[31:16];
                            pc_next       = pc + 32'd2;
                            state_next    = MISALIGNED;
                        end
                    end
                end
                MISALIGNED: begin
                    if (residue[1:0] != 2'b11) begin
                        // The residue alone is a full instruction; the word waits.
                        instr_valid_o      = 1'b1;
                        instr_aligned_o    = {16'h0, residue};
                        instr_compressed_o = 1'b1;
                        if (if_ready_i) begin
                            pc_next    = pc + 32'd2;
                            state_next = ALIGNED;
                        end
                    end else begin
                        instr_valid_o   = fetch_valid_i;
                        instr_aligned_o = {fetch_rdata_i[15:0], residue};
                        if (fetch_valid_i && if_ready_i) begin
                            fetch_ready_o = 1'b1;
                            residue_next  = fetch_rdata_i[31:16];
                            pc_next       = pc + 32'd4;
                        end
                    end
                end
                BRANCH_MIS: begin
                    // Drop the lower half of the target word: one bubble cycle.
                    fetch_ready_o = fetch_valid_i;
                    if (fetch_valid_i) begin
                        residue_next = fetch_rdata_i[31:16];
                        state_next   = MISALIGNED;
                    end
                end
                default: begin
                    state_next = ALIGNED;
                end
            endcase
        end
        if (!instr_valid_o) begin
            instr_aligned_o    = 32'h0;
            instr_compressed_o = 1'b0;
        end
    end

    // State, PC and residue registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ALIGNED;
            pc      <= BOOT_ADDR;
            residue <= 16'h0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            residue <= residue_next;
        end
    end
`else
    logic unused_addr_bits;

    // Without compressed support targets are word aligned.
    assign unused_addr_bits = ^branch_addr_i[1:0];

    // Every valid word is presented as one 32-bit instruction.
    always_comb begin
        instr_valid_o      = 1'b0;
        fetch_ready_o      = 1'b0;
        instr_aligned_o    = 32'h0;
        instr_compressed_o = 1'b0;
        pc_next            = pc;
        if (!rst_n) begin
            pc_next = pc;
        end else if (branch_i) begin
            pc_next = {branch_addr_i[31:2], 2'b00};
        end else begin
            instr_valid_o = fetch_valid_i;
            if (fetch_valid_i) begin
                instr_aligned_o = fetch_rdata_i;
                if (if_ready_i) begin
                    fetch_ready_o = 1'b1;
                    pc_next       = pc + 32'd4;
                end
            end
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= BOOT_ADDR;
        end else begin
            pc <= pc_next;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_fetch_aligner
// Description : Self-checking bench for cv32e40p_fetch_aligner. A directed
//               cycle table covers the named scenarios; random traffic is
//               compared against a halfword-queue reference model.
//               Follows FETCH_ALIGNER_RVC_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        if_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_aligned_o;
    logic        instr_compressed_o;
    logic [31:0] pc_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40p_fetch_aligner #(.BOOT_ADDR(32'h0000_0000)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_rdata_i      (fetch_rdata_i),
        .fetch_ready_o      (fetch_ready_o),
        .if_ready_i         (if_ready_i),
        .instr_valid_o      (instr_valid_o),
        .instr_aligned_o    (instr_aligned_o),
        .instr_compressed_o (instr_compressed_o),
        .pc_o               (pc_o),
        .branch_i           (branch_i),
        .branch_addr_i      (branch_addr_i)
    );

    typedef struct {
        logic        rst_n;
        logic        fv;
        logic [31:0] rd;
        logic        ir;
        logic        br;
        logic [31:0] ba;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_instr;
        logic        e_comp;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tab[$];

    // Reference model: halfwords already taken from the prefetch buffer,
    // the PC, and a pending "drop low half" after a misaligned redirect.
    logic [31:0] m_pc;
    logic [15:0] m_q[$];
    logic        m_skip;

    function automatic logic is_long(input logic [15:0] h);
`ifdef FETCH_ALIGNER_RVC_EN
        return h[1:0] == 2'b11;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic fv, input logic [31:0] rd, input logic ir,
                       input logic br, input logic [31:0] ba, input logic ev, input logic er,
                       input logic [31:0] ei, input logic ec, input logic [31:0] ep);
        vec_t v;
        v.rst_n = r; v.fv = fv; v.rd = rd; v.ir = ir; v.br = br; v.ba = ba;
        v.e_valid = ev; v.e_ready = er; v.e_instr = ei; v.e_comp = ec; v.e_pc = ep;
        tab.push_back(v);
    endtask

    // Called at posedge+1: drive, compare at the falling edge, advance model.
    task automatic apply(input vec_t v, input bit use_tab);
        logic        ev, er, ec;
        logic [31:0] ei, npc;
        logic [15:0] h[4];
        logic [15:0] nq[$];
        logic        nskip;
        int          n, nqsize, len;
        rst_n = v.rst_n; fetch_valid_i = v.fv; fetch_rdata_i = v.rd;
        if_ready_i = v.ir; branch_i = v.br; branch_addr_i = v.ba;
        #4;
        ev = 1'b0; er = 1'b0; ei = 32'h0; ec = 1'b0;
        npc = m_pc; nq = m_q; nskip = m_skip;
        if (!v.rst_n) begin
            npc = 32'h0; nq.delete(); nskip = 1'b0;
        end else if (v.br) begin
`ifdef FETCH_ALIGNER_RVC_EN
            npc = v.ba & 32'hFFFF_FFFE; nskip = v.ba[1];
`else
            npc = v.ba & 32'hFFFF_FFFC; nskip = 1'b0;
`endif
            nq.delete();
        end else if (m_skip) begin
            er = v.fv;
            if (v.fv) begin
                nq.delete(); nq.push_back(v.rd[31:16]); nskip = 1'b0;
            end
        end else begin
            n = 0;
            foreach (m_q[i]) begin h[n] = m_q[i]; n++; end
            nqsize = n;
            if (v.fv) begin h[n] = v.rd[15:0]; h[n+1] = v.rd[31:16]; n += 2; end
            if (n > 0) begin
                len = is_long(h[0]) ? 2 : 1;
                if (n >= len) begin
                    ev = 1'b1;
                    ec = (len == 1);
                    ei = (len == 2) ? {h[1], h[0]} : {16'h0, h[0]};
                    if (v.ir) begin
                        npc = m_pc + 32'(2 * len);
                        nq.delete();
                        if (len > nqsize) begin
                            er = 1'b1;
                            for (int k = len; k < n; k++) nq.push_back(h[k]);
                        end else begin
                            for (int k = len; k < nqsize; k++) nq.push_back(h[k]);
                        end
                    end
                end
            end
        end
        check32("model instr_valid", 32'(instr_valid_o), 32'(ev));
        check32("model fetch_ready", 32'(fetch_ready_o), 32'(er));
        check32("model instr_aligned", instr_aligned_o, ei);
        check32("model instr_compressed", 32'(instr_compressed_o), 32'(ec));
        check32("model pc", pc_o, m_pc);
        if (use_tab) begin
            check32("table instr_valid", 32'(instr_valid_o), 32'(v.e_valid));
            check32("table fetch_ready", 32'(fetch_ready_o), 32'(v.e_ready));
            check32("table instr_aligned", instr_aligned_o, v.e_instr);
            check32("table instr_compressed", 32'(instr_compressed_o), 32'(v.e_comp));
            check32("table pc", pc_o, v.e_pc);
        end
        @(posedge clk);
        #1;
        m_pc = npc; m_q = nq; m_skip = nskip;
    endtask

    initial begin
        vec_t v;
        // Common directed rows: reset, two 32-bit words, stall, no-valid.
        add(0, 1, 32'h0000_0013, 1, 0, 0,  0, 0, 32'h0,          0, 32'h0);
        add(1, 1, 32'h0000_0013, 1, 0, 0,  1, 1, 32'h0000_0013,  0, 32'h0);
        add(1, 1, 32'h0040_0093, 1, 0, 0,  1, 1, 32'h0040_0093,  0, 32'h4);
        for (int i = 0; i < 3; i++)
            add(1, 1, 32'h0000_0013, 0, 0, 0, 1, 0, 32'h0000_0013, 0, 32'h8);
        add(1, 1, 32'h0000_0013, 1, 0, 0,  1, 1, 32'h0000_0013,  0, 32'h8);
        add(1, 0, 32'h0000_0013, 1, 0, 0,  0, 0, 32'h0,          0, 32'hC);
`ifdef FETCH_ALIGNER_RVC_EN
        add(1, 1, 32'h4505_4501, 1, 0, 0,  1, 1, 32'h0000_4501,  1, 32'hC);
        add(1, 1, 32'h0000_0013, 1, 0, 0,  1, 0, 32'h0000_4505,  1, 32'hE);
        add(0, 0, 32'h0,         1, 0, 0,  0, 0, 32'h0,          0, 32'h10);
        add(1, 1, 32'h0013_4501, 1, 0, 0,  1, 1, 32'h0000_4501,  1, 32'h0);
        add(1, 1, 32'h4505_0000, 1, 0, 0,  1, 1, 32'h0000_0013,  0, 32'h2);
        add(1, 0, 32'h0,         1, 0, 0,  1, 0, 32'h0000_4505,  1, 32'h6);
        add(1, 1, 32'h0000_0013, 1, 1, 32'h102, 0, 0, 32'h0,     0, 32'h8);
        add(1, 1, 32'h0093_ABCD, 1, 0, 0,  0, 1, 32'h0,          0, 32'h102);
        add(1, 1, 32'h1234_0040, 1, 0, 0,  1, 1, 32'h0040_0093,  0, 32'h102);
        add(1, 0, 32'h0,         1, 0, 0,  1, 0, 32'h0000_1234,  1, 32'h106);
        add(1, 0, 32'h0,         1, 1, 32'h102, 0, 0, 32'h0,     0, 32'h108);
        add(1, 1, 32'h0001_ABCD, 1, 0, 0,  0, 1, 32'h0,          0, 32'h102);
        add(0, 0, 32'h0,         1, 1, 32'h206, 0, 0, 32'h0,     0, 32'h102);
        add(1, 0, 32'h0,         1, 0, 0,  0, 0, 32'h0,          0, 32'h0);
`else
        add(1, 1, 32'h4505_4501, 1, 0, 0,  1, 1, 32'h4505_4501,  0, 32'hC);
        add(1, 1, 32'h0000_0013, 1, 1, 32'h102, 0, 0, 32'h0,     0, 32'h10);
        add(1, 1, 32'h0000_0013, 1, 0, 0,  1, 1, 32'h0000_0013,  0, 32'h100);
        add(1, 1, 32'h0000_0013, 1, 1, 32'hFFFF_FFFE, 0, 0, 32'h0, 0, 32'h104);
        add(1, 1, 32'h0000_0013, 1, 0, 0,  1, 1, 32'h0000_0013,  0, 32'hFFFF_FFFC);
        add(1, 0, 32'h0,         1, 0, 0,  0, 0, 32'h0,          0, 32'h0);
        add(0, 1, 32'h4505_4501, 1, 1, 32'h300, 0, 0, 32'h0,     0, 32'h0);
        add(1, 1, 32'h4505_4501, 1, 0, 0,  1, 1, 32'h4505_4501,  0, 32'h0);
        add(1, 0, 32'h0,         1, 0, 0,  0, 0, 32'h0,          0, 32'h4);
`endif
        // Initial reset so the PC register is defined before any check.
        rst_n = 1'b0; fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0;
        if_ready_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
        m_pc = 32'h0; m_q.delete(); m_skip = 1'b0;
        @(posedge clk);
        #1;
        foreach (tab[i]) apply(tab[i], 1'b1);

        // Random traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            v.rst_n = ($urandom_range(0, 63) != 0);
            v.fv    = ($urandom_range(0, 3) != 0);
            v.rd    = $urandom;
            v.ir    = ($urandom_range(0, 3) != 0);
            v.br    = ($urandom_range(0, 15) == 0);
            v.ba    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            v.e_valid = 1'b0; v.e_ready = 1'b0; v.e_instr = 32'h0;
            v.e_comp = 1'b0; v.e_pc = 32'h0;
            apply(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
